// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID->EX stage bundle: decode fields in, EX register copies and stall out
interface id_ex_stage_if #(
    parameter int CTRL_W = 8
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1Addr;
    logic [4:0]        id_rs2Addr;
    logic [4:0]        id_rdAddr;
    logic              id_usesRs1;
    logic              id_usesRs2;
    logic [31:0]       rs1Data;
    logic [31:0]       rs2Data;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_MemRead;
    logic              id_MemWrite;
    logic              id_RegWrite;
    logic              flush;
    logic              ex_ready;

    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_rs1Data;
    logic [31:0]       ex_rs2Data;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rs1Addr;
    logic [4:0]        ex_rs2Addr;
    logic [4:0]        ex_rdAddr;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_RegWrite;
    logic              stall;

    modport master (
        output id_valid, id_pc, id_rs1Addr, id_rs2Addr, id_rdAddr, id_usesRs1, id_usesRs2,
               rs1Data, rs2Data, id_imm, id_ctrl, id_MemRead, id_MemWrite, id_RegWrite,
               flush, ex_ready,
        input  ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1Addr, ex_rs2Addr,
               ex_rdAddr, ex_ctrl, ex_MemRead, ex_MemWrite, ex_RegWrite, stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1Addr, id_rs2Addr, id_rdAddr, id_usesRs1, id_usesRs2,
               rs1Data, rs2Data, id_imm, id_ctrl, id_MemRead, id_MemWrite, id_RegWrite,
               flush, ex_ready,
        output ex_valid, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1Addr, ex_rs2Addr,
               ex_rdAddr, ex_ctrl, ex_MemRead, ex_MemWrite, ex_RegWrite, stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID->EX pipeline register with load-use stall; ID_EX_PERF_EN adds perf counters
module id_ex_stage #(
    parameter int CTRL_W = 8
`ifdef ID_EX_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_if.slave     bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] bubbleCount
`endif
);
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic bubble;

    assign rs1_hit = bus.id_usesRs1 && (bus.id_rs1Addr == bus.ex_rdAddr);
    assign rs2_hit = bus.id_usesRs2 && (bus.id_rs2Addr == bus.ex_rdAddr);
    assign hazard  = bus.ex_valid && bus.ex_MemRead && (bus.ex_rdAddr != 5'd0) &&
                     bus.id_valid && (rs1_hit || rs2_hit);
    // A flushed ID instruction is dead, so it must not hold the front end.
    assign bus.stall = !bus.ex_ready || (hazard && !bus.flush);
    assign bubble    = bus.flush || hazard;

    always_ff @(posedge clk) begin
        if (!rst_n || (bus.ex_ready && bubble)) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= 32'd0;
            bus.ex_rs1Data  <= 32'd0;
            bus.ex_rs2Data  <= 32'd0;
            bus.ex_imm      <= 32'd0;
            bus.ex_rs1Addr  <= 5'd0;
            bus.ex_rs2Addr  <= 5'd0;
            bus.ex_rdAddr   <= 5'd0;
            bus.ex_ctrl     <= {CTRL_W{1'b0}};
            bus.ex_MemRead  <= 1'b0;
            bus.ex_MemWrite <= 1'b0;
            bus.ex_RegWrite <= 1'b0;
        end else if (bus.ex_ready) begin
            bus.ex_valid    <= bus.id_valid;
            bus.ex_pc       <= bus.id_pc;
            bus.ex_rs1Data  <= bus.rs1Data;
            bus.ex_rs2Data  <= bus.rs2Data;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_rs1Addr  <= bus.id_rs1Addr;
            bus.ex_rs2Addr  <= bus.id_rs2Addr;
            bus.ex_rdAddr   <= bus.id_rdAddr;
            bus.ex_ctrl     <= bus.id_valid ? bus.id_ctrl : {CTRL_W{1'b0}};
            bus.ex_MemRead  <= bus.id_valid && bus.id_MemRead;
            bus.ex_MemWrite <= bus.id_valid && bus.id_MemWrite;
            bus.ex_RegWrite <= bus.id_valid && bus.id_RegWrite;
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCycles <= {CNT_W{1'b0}};
            bubbleCount <= {CNT_W{1'b0}};
        end else begin
            if (bus.stall && (stallCycles != {CNT_W{1'b1}}))
                stallCycles <= stallCycles + 1'b1;
            if (bus.ex_ready && bubble && (bubbleCount != {CNT_W{1'b1}}))
                bubbleCount <= bubbleCount + 1'b1;
        end
    end
`endif
endmodule
